// File: rtl/free_list_pkg.sv
// Shared sizing constants for the physical-register free list.
package free_list_pkg;

    localparam int unsigned PHY_NUM     = 64;
    localparam int unsigned ARCH_NUM    = 32;
    localparam int unsigned FL_NUM      = PHY_NUM - ARCH_NUM;
    localparam int unsigned PHY_REG_SEL = 6;
    localparam int unsigned REG_SEL     = 5;
    localparam int unsigned FL_SEL      = 5;
    localparam int unsigned CNT_W       = FL_SEL + 1;

endpackage

// File: rtl/free_list.sv
// Free physical-tag queue for rename: two allocations and two commit releases
// per cycle, with a committed-head pointer used to restore on misprediction.
module free_list
    import free_list_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alloc_req_1,
    input  logic                   alloc_req_2,
    input  logic                   stall_DP,
    output logic [PHY_REG_SEL-1:0] alloc_tag_1,
    output logic [PHY_REG_SEL-1:0] alloc_tag_2,
    output logic                   alloc_ready,
    output logic [CNT_W-1:0]       free_count,
    input  logic                   commit_valid_1,
    input  logic                   commit_valid_2,
    input  logic [REG_SEL-1:0]     commit_dst_1,
    input  logic [REG_SEL-1:0]     commit_dst_2,
    input  logic [PHY_REG_SEL-1:0] commit_release_tag_1,
    input  logic [PHY_REG_SEL-1:0] commit_release_tag_2,
    input  logic                   prmiss
);

    logic [PHY_REG_SEL-1:0] tags [FL_NUM];
    logic [FL_SEL-1:0]      head;
    logic [FL_SEL-1:0]      tail;
    logic [FL_SEL-1:0]      commit_head;
    logic [CNT_W-1:0]       count;

    logic [1:0]             reqnum;
    logic [1:0]             relnum;
    logic [1:0]             grant;
    logic                   rel_1;
    logic                   rel_2;
    logic [FL_SEL-1:0]      wr_idx_1;
    logic [FL_SEL-1:0]      wr_idx_2;
    logic [FL_SEL-1:0]      head_next;
    logic [FL_SEL-1:0]      tail_next;
    logic [FL_SEL-1:0]      commit_head_next;
    logic [FL_SEL-1:0]      flush_free;
    logic [CNT_W-1:0]       count_next;

    // Request/release decode and next-state pointer arithmetic (mod 32).
    always_comb begin
        reqnum           = 2'd0;
        relnum           = 2'd0;
        grant            = 2'd0;
        rel_1            = 1'b0;
        rel_2            = 1'b0;
        wr_idx_1         = tail;
        wr_idx_2         = tail;
        head_next        = head;
        tail_next        = tail;
        commit_head_next = commit_head;
        flush_free       = '0;
        count_next       = count;
        alloc_ready      = 1'b0;

        if (alloc_req_1) begin
            reqnum = alloc_req_2 ? 2'd2 : 2'd1;
        end
        alloc_ready = (count >= CNT_W'(reqnum));

        rel_1  = commit_valid_1 && (commit_dst_1 != '0);
        rel_2  = commit_valid_2 && (commit_dst_2 != '0);
        relnum = 2'({1'b0, rel_1}) + 2'({1'b0, rel_2});

        // Slot 2 lands right after slot 1 only when slot 1 also released.
        wr_idx_2         = tail + FL_SEL'(rel_1);
        tail_next        = tail + FL_SEL'(relnum);
        commit_head_next = commit_head + FL_SEL'(relnum);

        if (alloc_ready && !stall_DP && !prmiss) begin
            grant = reqnum;
        end

        if (prmiss) begin
            // Discard every uncommitted allocation; equal pointers mean full.
            head_next  = commit_head_next;
            flush_free = tail_next - head_next;
            count_next = (flush_free == '0) ? CNT_W'(FL_NUM) : CNT_W'(flush_free);
        end else begin
            head_next  = head + FL_SEL'(grant);
            count_next = count + CNT_W'(relnum) - CNT_W'(grant);
        end
    end

    // Tag array and pointer/count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(FL_NUM); i++) begin
                tags[i] <= PHY_REG_SEL'(ARCH_NUM + 32'(i));
            end
            head        <= '0;
            tail        <= '0;
            commit_head <= '0;
            count       <= CNT_W'(FL_NUM);
        end else begin
            if (rel_1) begin
                tags[wr_idx_1] <= commit_release_tag_1;
            end
            if (rel_2) begin
                tags[wr_idx_2] <= commit_release_tag_2;
            end
            head        <= head_next;
            tail        <= tail_next;
            commit_head <= commit_head_next;
            count       <= count_next;
        end
    end

    // Tags offered to rename come straight from the queue head.
    always_comb begin
        alloc_tag_1 = tags[head];
        alloc_tag_2 = tags[head + FL_SEL'(1)];
        free_count  = count;
    end

endmodule
